// File: rtl/spi_frame_serializer.sv
// spi_frame_serializer
//   Accepts one command frame (opcode, address, optional payload) per valid/ready handshake
//   and shifts it out on a generated SPI clock, framed by an active-low chip select.
//   The field order on the wire is always opcode, address, payload. LSB_FIRST only
//   reverses the bit order inside each field.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   valid_in   frame request
//   ready_out  block can accept a frame
//   opcode     opcode field
//   addr       address field
//   data       payload field, sent only when data_en is high
//   data_en    append the payload to the frame
//   spi_clk    generated serial clock, idles at CPOL
//   spi_cs_n   chip select, active low
//   mosi       serial data out
//   busy       frame in progress
//   done       one-cycle pulse at the end of a frame
module spi_frame_serializer #(
    parameter int unsigned OPCODEW   = 2,
    parameter int unsigned ADDRW     = 8,
    parameter int unsigned DATAW     = 8,
    parameter int unsigned CLKDIV    = 2,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          CPOL      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [OPCODEW-1:0] opcode,
    input  logic [ADDRW-1:0]   addr,
    input  logic [DATAW-1:0]   data,
    input  logic               data_en,
    output logic               spi_clk,
    output logic               spi_cs_n,
    output logic               mosi,
    output logic               busy,
    output logic               done
);

    localparam int unsigned FrameW  = OPCODEW + ADDRW + DATAW;
    localparam int unsigned BitCntW = $clog2(FrameW + 1);
    localparam int unsigned DivCntW = $clog2(CLKDIV + 1);

    // Bit counter holds the number of bits still to send after the one on mosi.
    localparam logic [BitCntW-1:0] LongLast  = BitCntW'(FrameW - 1);
    localparam logic [BitCntW-1:0] ShortLast = BitCntW'(OPCODEW + ADDRW - 1);
    localparam logic [DivCntW-1:0] DivLast   = DivCntW'(CLKDIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e               state_q, state_d;
    logic [FrameW-1:0]    shreg_q, shreg_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DivCntW-1:0]   div_cnt_q, div_cnt_d;
    logic                 spi_clk_q, spi_clk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 mosi_q, mosi_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [OPCODEW-1:0]   op_ord;
    logic [ADDRW-1:0]     addr_ord;
    logic [DATAW-1:0]     data_ord;
    logic [FrameW-1:0]    frame;
    logic                 div_last;

    // Each field is reordered so the next bit to send is always at the frame MSB.
    always_comb begin
        for (int i = 0; i < int'(OPCODEW); i++) begin
            op_ord[i] = LSB_FIRST ? opcode[int'(OPCODEW) - 1 - i] : opcode[i];
        end
        for (int i = 0; i < int'(ADDRW); i++) begin
            addr_ord[i] = LSB_FIRST ? addr[int'(ADDRW) - 1 - i] : addr[i];
        end
        for (int i = 0; i < int'(DATAW); i++) begin
            data_ord[i] = LSB_FIRST ? data[int'(DATAW) - 1 - i] : data[i];
        end
        frame = {op_ord, addr_ord, data_ord};
    end

    assign div_last = (div_cnt_q == DivLast);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        spi_clk_d = spi_clk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in && ready_q) begin
                    state_d   = StShift;
                    mosi_d    = frame[FrameW-1];
                    shreg_d   = {frame[FrameW-2:0], 1'b0};
                    bit_cnt_d = data_en ? LongLast : ShortLast;
                    div_cnt_d = '0;
                    spi_clk_d = CPOL;
                    cs_n_d    = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            StShift: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (spi_clk_q == CPOL) begin
                        // Leading edge: the peripheral samples mosi here.
                        spi_clk_d = ~CPOL;
                    end else begin
                        // Trailing edge closes the bit period; mosi only moves here.
                        spi_clk_d = CPOL;
                        if (bit_cnt_q == '0) begin
                            state_d = StHold;
                        end else begin
                            mosi_d    = shreg_q[FrameW-1];
                            shreg_d   = {shreg_q[FrameW-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - BitCntW'(1);
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivCntW'(1);
                end
            end

            StHold: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = StIdle;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    div_cnt_d = div_cnt_q + DivCntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            spi_clk_q <= CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            spi_clk_q <= spi_clk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready_out = ready_q;
    assign busy      = busy_q;
    assign spi_clk   = spi_clk_q;
    assign spi_cs_n  = cs_n_q;
    assign mosi      = mosi_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spi_frame_serializer.sv
// tb_spi_frame_serializer
//   Three instances: 0 = defaults, 1 = LSB_FIRST, 2 = CPOL=1 with CLKDIV=1.
//   Expected waveforms come from a cycle-indexed model of the frame timing and a
//   bit list built from the field values.
module tb_spi_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n, valid_in, ready_out, data_en, spi_clk, spi_cs_n, mosi, busy, done;
    logic [1:0] opcode [3];
    logic [7:0] addr   [3];
    logic [7:0] data   [3];

    int checks   = 0;
    int failures = 0;

    spi_frame_serializer #(
        .OPCODEW(2), .ADDRW(8), .DATAW(8), .CLKDIV(2), .LSB_FIRST(1'b0), .CPOL(1'b0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .valid_in(valid_in[0]), .ready_out(ready_out[0]),
        .opcode(opcode[0]), .addr(addr[0]), .data(data[0]), .data_en(data_en[0]),
        .spi_clk(spi_clk[0]), .spi_cs_n(spi_cs_n[0]), .mosi(mosi[0]), .busy(busy[0]),
        .done(done[0])
    );

    spi_frame_serializer #(
        .OPCODEW(2), .ADDRW(8), .DATAW(8), .CLKDIV(2), .LSB_FIRST(1'b1), .CPOL(1'b0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .valid_in(valid_in[1]), .ready_out(ready_out[1]),
        .opcode(opcode[1]), .addr(addr[1]), .data(data[1]), .data_en(data_en[1]),
        .spi_clk(spi_clk[1]), .spi_cs_n(spi_cs_n[1]), .mosi(mosi[1]), .busy(busy[1]),
        .done(done[1])
    );

    spi_frame_serializer #(
        .OPCODEW(2), .ADDRW(8), .DATAW(8), .CLKDIV(1), .LSB_FIRST(1'b0), .CPOL(1'b1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .valid_in(valid_in[2]), .ready_out(ready_out[2]),
        .opcode(opcode[2]), .addr(addr[2]), .data(data[2]), .data_en(data_en[2]),
        .spi_clk(spi_clk[2]), .spi_cs_n(spi_cs_n[2]), .mosi(mosi[2]), .busy(busy[2]),
        .done(done[2])
    );

    function automatic int cdiv(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    function automatic logic cpol(input int d);
        return (d == 2);
    endfunction

    function automatic logic lsb(input int d);
        return (d == 1);
    endfunction

    task automatic chk1(input string tag, input int d, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%b exp=%b", tag, d, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int d);
        chk1({tag, "_ready"}, d, ready_out[d], 1'b1);
        chk1({tag, "_busy"},  d, busy[d],      1'b0);
        chk1({tag, "_cs_n"},  d, spi_cs_n[d],  1'b1);
        chk1({tag, "_sclk"},  d, spi_clk[d],   cpol(d));
        chk1({tag, "_mosi"},  d, mosi[d],      1'b0);
        chk1({tag, "_done"},  d, done[d],      1'b0);
    endtask

    // Called at a falling edge. Drives a request, waits for the accept edge E0, then checks
    // every cycle up to and including the done cycle. Returns at the falling edge of the done
    // cycle. cap collects mosi at each leading spi_clk edge (first bit ends up most significant).
    task automatic do_frame(input int d, input logic [1:0] op, input logic [7:0] ad,
                            input logic [7:0] da, input logic de, input bit hold,
                            input bit imm, output logic [31:0] cap);
        int   n, c, t_end, waits, k;
        logic cp, pclk, exp_clk, exp_mosi;
        logic eb [18];

        c  = cdiv(d);
        cp = cpol(d);
        n  = de ? 18 : 10;
        k  = 0;
        for (int j = 0; j < 2; j++) begin
            eb[k] = op[lsb(d) ? j : 1 - j];
            k++;
        end
        for (int j = 0; j < 8; j++) begin
            eb[k] = ad[lsb(d) ? j : 7 - j];
            k++;
        end
        for (int j = 0; j < 8; j++) begin
            eb[k] = de ? da[lsb(d) ? j : 7 - j] : 1'b0;
            k++;
        end

        opcode[d]   = op;
        addr[d]     = ad;
        data[d]     = da;
        data_en[d]  = de;
        valid_in[d] = 1'b1;

        waits = 0;
        while (ready_out[d] !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (imm) chk32("accept_gap", d, waits, 0);
        chk1("ready_before_accept", d, ready_out[d], 1'b1);

        @(posedge clk);
        @(negedge clk);
        if (!hold) valid_in[d] = 1'b0;
        // Inputs change while busy; the frame in flight must not notice.
        opcode[d]  = 2'($urandom);
        addr[d]    = 8'($urandom);
        data[d]    = 8'($urandom);
        data_en[d] = 1'($urandom);

        t_end = (2 * n + 1) * c;
        pclk  = cp;
        k     = 0;
        cap   = '0;
        for (int t = 0; t <= t_end; t++) begin
            exp_clk  = (t < 2 * n * c && (t % (2 * c)) >= c) ? ~cp : cp;
            exp_mosi = (t < 2 * n * c) ? eb[t / (2 * c)] : (t < t_end) ? eb[n - 1] : 1'b0;
            chk1("cs_n",  d, spi_cs_n[d],  (t < t_end) ? 1'b0 : 1'b1);
            chk1("sclk",  d, spi_clk[d],   exp_clk);
            chk1("mosi",  d, mosi[d],      exp_mosi);
            chk1("done",  d, done[d],      (t == t_end));
            chk1("ready", d, ready_out[d], (t == t_end));
            chk1("busy",  d, busy[d],      (t != t_end));
            if (pclk == cp && spi_clk[d] == ~cp) begin
                if (k < 18) chk1("lead_edge_bit", d, mosi[d], eb[k]);
                cap = {cap[30:0], mosi[d]};
                k++;
            end
            pclk = spi_clk[d];
            if (t < t_end) @(negedge clk);
        end
        chk32("lead_edge_count", d, k, n);
    endtask

    initial begin
        logic [31:0] cap;

        rst_n    = 3'b000;
        valid_in = 3'b000;
        data_en  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            opcode[d] = '0;
            addr[d]   = '0;
            data[d]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle("reset", d);
        rst_n = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle("after_reset", d);

        // Directed frames with known bit patterns.
        do_frame(0, 2'b10, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, cap);
        chk32("t1_bits", 0, cap, 32'h0000_02A5);
        @(negedge clk);
        do_frame(0, 2'b01, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, cap);
        chk32("t2_bits", 0, cap, 32'h0001_003C);
        @(negedge clk);
        do_frame(1, 2'b10, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, cap);
        chk32("t3_bits", 1, cap, 32'h0000_0180);

        // Back-to-back frames with valid held high: each accepted right after done.
        @(negedge clk);
        do_frame(0, 2'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, cap);
        do_frame(0, 2'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, cap);
        do_frame(0, 2'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b1, cap);
        @(negedge clk);
        chk_idle("after_b2b", 0);

        // CPOL=1, CLKDIV=1.
        do_frame(2, 2'b11, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, cap);
        chk32("t5_bits", 2, cap, 32'h0000_035A);
        @(negedge clk);

        // Randomized frames on every instance.
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 3; d++) begin
                do_frame(d, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                         1'b0, 1'b0, cap);
                @(negedge clk);
            end
        end

        // Reset in the middle of bit 4: outputs drop to reset values without a clock edge.
        opcode[0]   = 2'b11;
        addr[0]     = 8'hFF;
        data_en[0]  = 1'b0;
        valid_in[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk1("pre_reset_cs_n", 0, spi_cs_n[0], 1'b0);
        chk1("pre_reset_busy", 0, busy[0], 1'b1);
        #1 rst_n[0] = 1'b0;
        #1;
        chk_idle("async_reset", 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk1("no_done_after_reset", 0, done[0], 1'b0);
            chk1("cs_n_after_reset", 0, spi_cs_n[0], 1'b1);
        end
        do_frame(0, 2'b10, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, cap);
        chk32("post_reset_bits", 0, cap, 32'h0000_02A5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
